auto_door_ctrl: RTL and testbench

Parametrised multi-channel automatic door controller, next generation of the single-door up/down motor controller. Drives open/close motors for N independent doors from limit-switch sensors. Adds auto-close hold timing, obstruction reversal, a travel-timeout fault with explicit clear, and sensor-conflict detection. Sits between the door sensor front end and the motor drivers, one instance per door bank.

---
 rtl/auto_door_pkg.sv | 27 ++
 rtl/auto_door_ctrl_door_fsm.sv | 148 ++++++++++++++
 rtl/auto_door_ctrl.sv | 49 ++++
 tb/tb_auto_door_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/auto_door_pkg.sv
`default_nettype none
// ============================================================================
// Module      : auto_door_pkg
// Description : Shared types and helpers for the automatic door controller.
//               Door state encoding is fixed so that it can be observed and
//               decoded by downstream debug logic.
// Revision    : 1.0 - initial release
// ============================================================================
package auto_door_pkg;

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_FAULT   = 3'd4
  } door_state_t;

  // Width of a counter able to hold the larger of the two timing limits.
  function automatic int cnt_width(input int hold_cycles, input int travel_cycles);
    int m;
    m = (hold_cycles > travel_cycles) ? hold_cycles : travel_cycles;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/auto_door_ctrl_door_fsm.sv
`default_nettype none
// ============================================================================
// Module      : door_fsm
// Description : One door channel: Moore FSM with travel-timeout counter and
//               auto-close hold counter. Motor and fault outputs are
//               registered together with the state so they never glitch.
// Revision    : 1.0 - initial release
// ============================================================================
module door_fsm
  import auto_door_pkg::*;
#(
  parameter int HOLD_CYCLES   = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter bit AUTO_CLOSE    = 1'b1
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_activate,
  input  logic i_up_max,
  input  logic i_dn_max,
  input  logic i_obstruct,
  input  logic i_fault_clr,
  output logic o_up_m,
  output logic o_dn_m,
  output logic o_fault
);

  localparam int c_CNT_W = cnt_width(HOLD_CYCLES, TRAVEL_CYCLES);
  localparam logic [c_CNT_W-1:0] c_HOLD_LOAD   = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TRAVEL_LAST = c_CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_ZERO        = '0;
  localparam logic [c_CNT_W-1:0] c_ONE         = c_CNT_W'(1);

  door_state_t        r_state;
  logic [c_CNT_W-1:0] r_travel;
  logic [c_CNT_W-1:0] r_hold;
  logic               r_up_m;
  logic               r_dn_m;
  logic               r_fault;

  // Both limit switches active at once can only be a broken sensor.
  logic w_conflict;
  assign w_conflict = i_up_max & i_dn_max;

  // Door state machine; outputs are updated only on state transitions so
  // they always reflect the registered state.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_CLOSED;
      r_travel <= c_ZERO;
      r_hold   <= c_ZERO;
      r_up_m   <= 1'b0;
      r_dn_m   <= 1'b0;
      r_fault  <= 1'b0;
    end else if (r_state != ST_FAULT && w_conflict) begin
      r_state  <= ST_FAULT;
      r_up_m   <= 1'b0;
      r_dn_m   <= 1'b0;
      r_fault  <= 1'b1;
    end else begin
      case (r_state)
        ST_CLOSED: begin
          if (i_activate) begin
            r_state  <= ST_OPENING;
            r_travel <= c_ZERO;
            r_up_m   <= 1'b1;
          end
        end

        ST_OPENING: begin
          // Reaching the limit on the timeout edge still counts as success.
          if (i_up_max) begin
            r_state <= ST_OPEN;
            r_hold  <= c_HOLD_LOAD;
            r_up_m  <= 1'b0;
          end else if (r_travel == c_TRAVEL_LAST) begin
            r_state <= ST_FAULT;
            r_up_m  <= 1'b0;
            r_fault <= 1'b1;
          end else begin
            r_travel <= r_travel + c_ONE;
          end
        end

        ST_OPEN: begin
          if (!AUTO_CLOSE && i_activate) begin
            r_state  <= ST_CLOSING;
            r_travel <= c_ZERO;
            r_dn_m   <= 1'b1;
          end else if (i_activate || i_obstruct) begin
            r_hold <= c_HOLD_LOAD;
          end else if (r_hold == c_ZERO) begin
            r_state  <= ST_CLOSING;
            r_travel <= c_ZERO;
            r_dn_m   <= 1'b1;
          end else begin
            r_hold <= r_hold - c_ONE;
          end
        end

        ST_CLOSING: begin
          if (i_dn_max) begin
            r_state <= ST_CLOSED;
            r_dn_m  <= 1'b0;
          end else if (i_obstruct || i_activate) begin
            // Reversal: travel budget starts over for the opening run.
            r_state  <= ST_OPENING;
            r_travel <= c_ZERO;
            r_dn_m   <= 1'b0;
            r_up_m   <= 1'b1;
          end else if (r_travel == c_TRAVEL_LAST) begin
            r_state <= ST_FAULT;
            r_dn_m  <= 1'b0;
            r_fault <= 1'b1;
          end else begin
            r_travel <= r_travel + c_ONE;
          end
        end

        ST_FAULT: begin
          // After acknowledge the door is driven shut; a persisting sensor
          // conflict is caught again on the next edge.
          if (i_fault_clr) begin
            r_state  <= ST_CLOSING;
            r_travel <= c_ZERO;
            r_dn_m   <= 1'b1;
            r_fault  <= 1'b0;
          end
        end

        default: begin
          r_state  <= ST_CLOSED;
          r_travel <= c_ZERO;
          r_hold   <= c_ZERO;
          r_up_m   <= 1'b0;
          r_dn_m   <= 1'b0;
          r_fault  <= 1'b0;
        end
      endcase
    end
  end

  assign o_up_m  = r_up_m;
  assign o_dn_m  = r_dn_m;
  assign o_fault = r_fault;

endmodule
`default_nettype wire

// File: rtl/auto_door_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : auto_door_ctrl
// Description : Multi-channel automatic door controller. One independent
//               door_fsm per channel; this level only slices the buses.
// Revision    : 1.0 - initial release
// ============================================================================
module auto_door_ctrl
  import auto_door_pkg::*;
#(
  parameter int N_DOORS       = 2,
  parameter int HOLD_CYCLES   = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter bit AUTO_CLOSE    = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_DOORS-1:0] Activate,
  input  logic [N_DOORS-1:0] UP_Max,
  input  logic [N_DOORS-1:0] DN_Max,
  input  logic [N_DOORS-1:0] Obstruct,
  input  logic [N_DOORS-1:0] Fault_Clr,
  output logic [N_DOORS-1:0] UP_M,
  output logic [N_DOORS-1:0] DN_M,
  output logic [N_DOORS-1:0] Fault
);

  // One channel per door, sharing only clock and reset.
  for (genvar gi = 0; gi < N_DOORS; gi++) begin : g_door
    door_fsm #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .TRAVEL_CYCLES (TRAVEL_CYCLES),
      .AUTO_CLOSE    (AUTO_CLOSE)
    ) u_door (
      .clk         (CLK),
      .i_rst_n     (RST),
      .i_activate  (Activate[gi]),
      .i_up_max    (UP_Max[gi]),
      .i_dn_max    (DN_Max[gi]),
      .i_obstruct  (Obstruct[gi]),
      .i_fault_clr (Fault_Clr[gi]),
      .o_up_m      (UP_M[gi]),
      .o_dn_m      (DN_M[gi]),
      .o_fault     (Fault[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_auto_door_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_auto_door_ctrl
// Description : Scoreboard bench for auto_door_ctrl. Two instances share the
//               stimulus: one with default timing and auto-close reload, one
//               with short timing and immediate close on Activate.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_auto_door_ctrl;

  localparam int N = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] act, upx, dnx, obs, clr;
  logic [N-1:0] up_a, dn_a, flt_a;
  logic [N-1:0] up_b, dn_b, flt_b;

  auto_door_ctrl #(.N_DOORS(N), .HOLD_CYCLES(8), .TRAVEL_CYCLES(16), .AUTO_CLOSE(1'b1)) dut (
    .CLK(clk), .RST(rst), .Activate(act), .UP_Max(upx), .DN_Max(dnx),
    .Obstruct(obs), .Fault_Clr(clr), .UP_M(up_a), .DN_M(dn_a), .Fault(flt_a)
  );

  auto_door_ctrl #(.N_DOORS(N), .HOLD_CYCLES(3), .TRAVEL_CYCLES(5), .AUTO_CLOSE(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .Activate(act), .UP_Max(upx), .DN_Max(dnx),
    .Obstruct(obs), .Fault_Clr(clr), .UP_M(up_b), .DN_M(dn_b), .Fault(flt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what each door is doing, how many cycles the motor has
  // been running, and how many cycles the door has been standing open.
  localparam int SHUT = 0, RAISE = 1, HELD = 2, LOWER = 3, BROKEN = 4;
  int mode    [2][N];
  int run_cyc [2][N];
  int open_cyc[2][N];

  int checks = 0;
  int errors = 0;
  bit running = 1'b1;

  logic [11:0] exp_q[$];

  function automatic int hold_of(int k);   return (k == 0) ? 8 : 3;  endfunction
  function automatic int travel_of(int k); return (k == 0) ? 16 : 5; endfunction
  function automatic bit recl_of(int k);   return (k == 0);          endfunction

  task automatic model_door(int k, int d, bit r, bit a, bit u, bit dm, bit o, bit c);
    if (!r) begin
      mode[k][d] = SHUT; run_cyc[k][d] = 0; open_cyc[k][d] = 0;
    end else if (mode[k][d] != BROKEN && u && dm) begin
      mode[k][d] = BROKEN;
    end else begin
      case (mode[k][d])
        SHUT:  if (a) begin mode[k][d] = RAISE; run_cyc[k][d] = 1; end
        RAISE: begin
          if (u) begin mode[k][d] = HELD; open_cyc[k][d] = 1; end
          else if (run_cyc[k][d] >= travel_of(k)) mode[k][d] = BROKEN;
          else run_cyc[k][d]++;
        end
        HELD: begin
          if (!recl_of(k) && a) begin mode[k][d] = LOWER; run_cyc[k][d] = 1; end
          else if (a || o) open_cyc[k][d] = 1;
          else if (open_cyc[k][d] >= hold_of(k)) begin mode[k][d] = LOWER; run_cyc[k][d] = 1; end
          else open_cyc[k][d]++;
        end
        LOWER: begin
          if (dm) mode[k][d] = SHUT;
          else if (o || a) begin mode[k][d] = RAISE; run_cyc[k][d] = 1; end
          else if (run_cyc[k][d] >= travel_of(k)) mode[k][d] = BROKEN;
          else run_cyc[k][d]++;
        end
        default: if (c) begin mode[k][d] = LOWER; run_cyc[k][d] = 1; end
      endcase
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, queue expectation.
  task automatic cycle(bit r, logic [N-1:0] a, logic [N-1:0] u, logic [N-1:0] dm,
                       logic [N-1:0] o, logic [N-1:0] c);
    logic [11:0] e;
    rst = r; act = a; upx = u; dnx = dm; obs = o; clr = c;
    @(posedge clk);
    e = '0;
    for (int k = 0; k < 2; k++)
      for (int d = 0; d < N; d++) begin
        model_door(k, d, r, a[d], u[d], dm[d], o[d], c[d]);
        e[k*6 + d*3 + 0] = (mode[k][d] == RAISE);
        e[k*6 + d*3 + 1] = (mode[k][d] == LOWER);
        e[k*6 + d*3 + 2] = (mode[k][d] == BROKEN);
      end
    exp_q.push_back(e);
    #1;
  endtask

  function automatic logic [N-1:0] rnd(int one_in);
    logic [N-1:0] v;
    for (int d = 0; d < N; d++) v[d] = ($urandom_range(one_in - 1) == 0);
    return v;
  endfunction

  // Monitor: every falling edge the DUT presents fresh outputs; compare them
  // against the oldest queued expectation.
  initial begin
    logic [11:0] e;
    logic [2:0]  got, want;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        if (running) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty t=%0t actual=no expectation required=one", $time);
        end
      end else begin
        e = exp_q.pop_front();
        for (int k = 0; k < 2; k++)
          for (int d = 0; d < N; d++) begin
            got  = (k == 0) ? {flt_a[d], dn_a[d], up_a[d]} : {flt_b[d], dn_b[d], up_b[d]};
            want = e[k*6 + d*3 +: 3];
            checks++;
            if (got !== want) begin
              errors++;
              $display("FAIL door_outputs inst=%0d door=%0d t=%0t {fault,dn,up} actual=%b required=%b",
                       k, d, $time, got, want);
            end
          end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized phases.
  initial begin
    rst = 1'b0; act = '0; upx = '0; dnx = '0; obs = '0; clr = '0;
    for (int k = 0; k < 2; k++)
      for (int d = 0; d < N; d++) begin
        mode[k][d] = SHUT; run_cyc[k][d] = 0; open_cyc[k][d] = 0;
      end

    // Reset while closed limit active, then a full open/hold/close run of door 0.
    repeat (3) cycle(1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    cycle(1'b1, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00);
    repeat (4) cycle(1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    repeat (10) cycle(1'b1, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00);
    repeat (3) cycle(1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    cycle(1'b1, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00);
    repeat (20) cycle(1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    // Sensor conflict on door 1, then clear.
    cycle(1'b1, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00);
    repeat (2) cycle(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
    repeat (4) cycle(1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    // Open door 0, keep re-activating every 5 cycles while open.
    cycle(1'b1, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00);
    cycle(1'b1, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00);
    for (int i = 0; i < 6; i++) begin
      repeat (4) cycle(1'b1, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00);
      cycle(1'b1, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00);
    end
    // Reset in the middle of travel, Activate held during reset.
    cycle(1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    repeat (2) cycle(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);

    // Randomized phases: sparse sensors (timeouts, auto-close) then busy ones.
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(199) != 0), rnd(12), rnd(30), rnd(30), rnd(25), rnd(10));
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(99) != 0), rnd(4), rnd(5), rnd(5), rnd(6), rnd(4));

    running = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d left required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
